// File: rtl/pcie_phy_tx_pkg.sv
// Shared types and constants for the Gen3 128b/130b TX framer.
// Holds block typing, sync header codes and the per-lane scrambler seeds.
package pcie_phy_tx_pkg;

    typedef enum logic {
        BlkData = 1'b0,
        BlkOs   = 1'b1
    } blk_type_e;

    typedef enum logic [1:0] {
        OsGeneric = 2'b00,
        OsSkp     = 2'b01,
        OsEieos   = 2'b10,
        OsRsvd    = 2'b11
    } os_kind_e;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_OS   = 2'b01;

    localparam int unsigned LFSR_W = 23;

    // x^23 term is implicit; remaining taps x^21+x^16+x^8+x^5+x^2+1
    localparam logic [LFSR_W-1:0] LFSR_POLY = 23'h210125;

    localparam logic [LFSR_W-1:0] LFSR_SEED [0:7] = '{
        23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
        23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807
    };

    function automatic logic [1:0] sync_hdr(input blk_type_e t);
        return (t == BlkOs) ? SYNC_OS : SYNC_DATA;
    endfunction

endpackage

// File: rtl/pcie_phy_tx_block_framer_lane_scrambler.sv
// Per-lane Galois LFSR scrambler; consumes one LFSR step per wire bit, LSB of byte 0 first.
// A whole lane beat (LANE_W steps) is evaluated combinationally each cycle.
module pcie_lane_scrambler
    import pcie_phy_tx_pkg::*;
#(
    parameter int unsigned       LANE_W = 32,
    parameter logic [LFSR_W-1:0] SEED   = 23'h1DBFBC
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              advance_i,
    input  logic              reload_i,
    input  logic              scramble_i,
    input  logic [LANE_W-1:0] data_i,
    output logic [LANE_W-1:0] data_o
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_adv;
    logic [LANE_W-1:0] keystream;

    always_comb begin
        lfsr_adv  = lfsr_q;
        keystream = '0;
        for (int unsigned i = 0; i < LANE_W; i++) begin
            keystream[i] = lfsr_adv[LFSR_W-1];
            lfsr_adv     = {lfsr_adv[LFSR_W-2:0], 1'b0} ^
                           (lfsr_adv[LFSR_W-1] ? LFSR_POLY : '0);
        end

        lfsr_d = lfsr_q;
        if (reload_i) begin
            lfsr_d = SEED;
        end else if (advance_i) begin
            lfsr_d = lfsr_adv;
        end
    end

    assign data_o = scramble_i ? (data_i ^ keystream) : data_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/pcie_phy_tx_block_framer.sv
// Gen3 TX block framer: tracks the 4-beat block position, applies per-lane scrambling rules
// by block type, flags framing errors and presents a 1-deep registered PIPE-style output.
module pcie_phy_tx_block_framer
    import pcie_phy_tx_pkg::*;
#(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned LANE_W      = 32,
    parameter bit          SCRAMBLE_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_LANES*LANE_W-1:0] in_data,
    input  logic                        in_sob,
    input  logic                        in_blk_type,
    input  logic [1:0]                  in_os_kind,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_LANES*LANE_W-1:0] out_data,
    output logic                        out_start_blk,
    output logic [1:0]                  out_sync_hdr,
    output logic                        err_framing
);

    logic [1:0] beat_cnt_q, beat_cnt_d;
    blk_type_e  blk_type_q, cur_type;
    os_kind_e   os_kind_q, cur_kind;

    logic accept, drop, emit, sob_err;
    logic scramble, lfsr_adv, lfsr_reload, last_beat;
    logic [NUM_LANES*LANE_W-1:0] scr_data;

    assign in_ready = out_ready || !out_valid;
    assign accept   = in_valid && in_ready;

    // A non-sob beat where a block must start is swallowed without touching the LFSRs
    assign drop    = accept && !in_sob && (beat_cnt_q == 2'd0);
    assign emit    = accept && !drop;
    assign sob_err = accept && in_sob && (beat_cnt_q != 2'd0);

    assign cur_type  = in_sob ? blk_type_e'(in_blk_type) : blk_type_q;
    assign cur_kind  = in_sob ? os_kind_e'(in_os_kind) : os_kind_q;
    assign last_beat = !in_sob && (beat_cnt_q == 2'd3);

    assign scramble    = SCRAMBLE_EN && (cur_type == BlkData);
    assign lfsr_adv    = emit && !((cur_type == BlkOs) && (cur_kind == OsSkp));
    assign lfsr_reload = emit && (cur_type == BlkOs) && (cur_kind == OsEieos) && last_beat;

    assign beat_cnt_d = in_sob ? 2'd1 : beat_cnt_q + 2'd1;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        pcie_lane_scrambler #(
            .LANE_W (LANE_W),
            .SEED   (LFSR_SEED[g % 8])
        ) u_scrambler (
            .clk_i      (clk),
            .rst_i      (reset),
            .advance_i  (lfsr_adv),
            .reload_i   (lfsr_reload),
            .scramble_i (scramble),
            .data_i     (in_data[g*LANE_W +: LANE_W]),
            .data_o     (scr_data[g*LANE_W +: LANE_W])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt_q    <= 2'd0;
            blk_type_q    <= BlkData;
            os_kind_q     <= OsGeneric;
            err_framing   <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_start_blk <= 1'b0;
            out_sync_hdr  <= 2'b00;
        end else begin
            if (sob_err || drop) begin
                err_framing <= 1'b1;
            end

            if (emit) begin
                beat_cnt_q    <= beat_cnt_d;
                out_valid     <= 1'b1;
                out_data      <= scr_data;
                out_start_blk <= in_sob;
                if (in_sob) begin
                    blk_type_q   <= cur_type;
                    os_kind_q    <= cur_kind;
                    out_sync_hdr <= sync_hdr(cur_type);
                end
            end else if (out_ready) begin
                out_valid     <= 1'b0;
                out_start_blk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pcie_phy_tx_block_framer.sv
// Directed bench for the TX block framer: a bypass and a scrambling instance share stimulus,
// and scrambled lanes are compared against a bit-serial reference LFSR.
module tb_pcie_phy_tx_block_framer;
    import pcie_phy_tx_pkg::*;

    localparam int unsigned NL = 4;
    localparam int unsigned DW = NL * 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          in_valid, in_sob, in_blk_type, out_ready;
    logic [1:0]    in_os_kind;
    logic [DW-1:0] in_data;

    logic          rdy_b, vld_b, sb_b, err_b;
    logic          rdy_s, vld_s, sb_s, err_s;
    logic [DW-1:0] dat_b, dat_s;
    logic [1:0]    sync_b, sync_s;

    pcie_phy_tx_block_framer #(.NUM_LANES(NL), .LANE_W(32), .SCRAMBLE_EN(1'b0)) u_byp (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
        .in_sob(in_sob), .in_blk_type(in_blk_type), .in_os_kind(in_os_kind),
        .out_valid(vld_b), .out_ready(out_ready), .out_data(dat_b), .out_start_blk(sb_b),
        .out_sync_hdr(sync_b), .err_framing(err_b)
    );

    pcie_phy_tx_block_framer #(.NUM_LANES(NL), .LANE_W(32), .SCRAMBLE_EN(1'b1)) u_scr (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data),
        .in_sob(in_sob), .in_blk_type(in_blk_type), .in_os_kind(in_os_kind),
        .out_valid(vld_s), .out_ready(out_ready), .out_data(dat_s), .out_start_blk(sb_s),
        .out_sync_hdr(sync_s), .err_framing(err_s)
    );

    int n_chk = 0;
    int n_pass = 0;
    logic [22:0] mdl [NL];
    logic [31:0] seed_ks [NL];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference Galois LFSR, one step per wire bit
    function automatic void lfsr_run(input logic [22:0] s, output logic [31:0] ks,
                                     output logic [22:0] ns);
        logic [22:0] t;
        t = s;
        for (int i = 0; i < 32; i++) begin
            ks[i] = t[22];
            t = t[22] ? ({t[21:0], 1'b0} ^ 23'h210125) : {t[21:0], 1'b0};
        end
        ns = t;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NL; n++) mdl[n] = LFSR_SEED[n];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_sob = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic xfer(input logic [DW-1:0] d, input bit sob, input bit os,
                        input logic [1:0] kind, input bit last, input string tag,
                        output logic [DW-1:0] exp_s);
        logic [31:0] ks;
        logic [22:0] ns;
        for (int n = 0; n < NL; n++) begin
            lfsr_run(mdl[n], ks, ns);
            exp_s[n*32 +: 32] = os ? d[n*32 +: 32] : (d[n*32 +: 32] ^ ks);
            if (os && kind == 2'b10 && last) mdl[n] = LFSR_SEED[n];
            else if (!(os && kind == 2'b01)) mdl[n] = ns;
        end
        in_data = d;
        in_sob = sob;
        in_blk_type = os;
        in_os_kind = kind;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".vld"}, {vld_s, vld_b}, 2'b11);
        chk({tag, ".byp"}, dat_b, d);
        chk({tag, ".scr"}, dat_s, exp_s);
        chk({tag, ".sob"}, {sb_s, sb_b}, {sob, sob});
        if (sob) chk({tag, ".sync"}, {sync_s, sync_b}, os ? 4'b0101 : 4'b1010);
    endtask

    task automatic idle(input string tag);
        in_valid = 1'b0;
        in_sob = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".idle"}, {vld_s, vld_b}, 2'b00);
    endtask

    task automatic blk(input logic [DW-1:0] d, input bit os, input logic [1:0] kind,
                       input string tag);
        logic [DW-1:0] e;
        for (int k = 0; k < 4; k++) xfer(d, k == 0, os, kind, k == 3, $sformatf("%s%0d", tag, k), e);
        idle(tag);
    endtask

    initial begin
        logic [DW-1:0] d, e, e0, zero, osp;
        logic [22:0] ns;
        zero = '0;
        osp = {NL{32'hAA55C3F0}};
        for (int n = 0; n < NL; n++) lfsr_run(LFSR_SEED[n], seed_ks[n], ns);
        out_ready = 1'b1;
        in_data = '0;
        in_blk_type = 1'b0;
        in_os_kind = 2'b00;
        do_reset();

        chk("rst.vld", {vld_s, vld_b}, 2'b00);
        chk("rst.data", {dat_s, dat_b}, 256'h0);
        chk("rst.sob_sync", {sb_s, sb_b, sync_s, sync_b}, 6'b0);
        chk("rst.err", {err_s, err_b}, 2'b00);
        chk("rst.rdy", {rdy_s, rdy_b}, 2'b11);

        // lane n beat k = {n,k,n,k}
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < NL; n++) d[n*32 +: 32] = {8'(n), 8'(k), 8'(n), 8'(k)};
            xfer(d, k == 0, 1'b0, 2'b00, k == 3, $sformatf("pat%0d", k), e);
            if (k == 0) chk("pat.seedks", dat_s ^ d, {seed_ks[3], seed_ks[2], seed_ks[1], seed_ks[0]});
        end
        idle("pat");

        xfer(zero, 1'b1, 1'b0, 2'b00, 1'b0, "z0", e);
        chk("z.lane_diff", {31'h0, dat_s[31:0] != dat_s[63:32]}, 32'h1);
        for (int k = 1; k < 4; k++) xfer(zero, 1'b0, 1'b0, 2'b00, k == 3, $sformatf("z%0d", k), e);
        blk(zero, 1'b0, 2'b00, "zb");

        blk(osp, 1'b1, 2'b01, "skp");
        blk(zero, 1'b0, 2'b00, "skpd");
        blk(osp, 1'b1, 2'b00, "gos");
        blk(zero, 1'b0, 2'b00, "gosd");
        blk(osp, 1'b1, 2'b11, "rsv");
        blk(osp, 1'b1, 2'b10, "eie");
        xfer(zero, 1'b1, 1'b0, 2'b00, 1'b0, "eied0", e);
        chk("eie.seedks", dat_s, {seed_ks[3], seed_ks[2], seed_ks[1], seed_ks[0]});
        for (int k = 1; k < 4; k++) xfer(zero, 1'b0, 1'b0, 2'b00, k == 3, $sformatf("eied%0d", k), e);
        idle("eied");

        // Backpressure: stall 5 cycles with beat 1 waiting
        xfer(zero, 1'b1, 1'b0, 2'b00, 1'b0, "bp0", e0);
        out_ready = 1'b0;
        in_data = {NL{32'h11223344}};
        in_sob = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp.rdy%0d", c), {rdy_s, rdy_b}, 2'b00);
            chk($sformatf("bp.vld%0d", c), {vld_s, vld_b, sb_s, sb_b}, 4'b1111);
            chk($sformatf("bp.hold%0d", c), dat_s, e0);
        end
        out_ready = 1'b1;
        xfer({NL{32'h11223344}}, 1'b0, 1'b0, 2'b00, 1'b0, "bp1", e);
        xfer({NL{32'h55667788}}, 1'b0, 1'b0, 2'b00, 1'b0, "bp2", e);
        xfer({NL{32'h99AABBCC}}, 1'b0, 1'b0, 2'b00, 1'b1, "bp3", e);
        idle("bp");

        // Framing: early sob, then a stray non-sob beat at a block boundary
        xfer(zero, 1'b1, 1'b0, 2'b00, 1'b0, "fr0", e);
        xfer(zero, 1'b0, 1'b0, 2'b00, 1'b0, "fr1", e);
        chk("fr.noerr", {err_s, err_b}, 2'b00);
        xfer(zero, 1'b1, 1'b0, 2'b00, 1'b0, "fr2", e);
        chk("fr.err_sob", {err_s, err_b}, 2'b11);
        for (int k = 1; k < 4; k++) xfer(zero, 1'b0, 1'b0, 2'b00, k == 3, $sformatf("fr%0d", k + 2), e);
        in_data = {NL{32'hDEADBEEF}};
        in_sob = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("fr.drop_vld", {vld_s, vld_b}, 2'b00);
        chk("fr.err_drop", {err_s, err_b}, 2'b11);
        in_valid = 1'b0;
        blk(zero, 1'b0, 2'b00, "frd");
        chk("fr.sticky", {err_s, err_b}, 2'b11);

        do_reset();
        chk("rst2.err", {err_s, err_b}, 2'b00);
        chk("rst2.vld", {vld_s, vld_b}, 2'b00);
        blk(zero, 1'b0, 2'b00, "post");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
